osc_tick_gen: RTL and testbench
===============================

// Module: osc_tick_gen
// PURPOSE
//  Multi-channel, runtime-programmable tick/divided-phase generator clocked by the on-chip oscillator.
//  Replaces fixed, build-time oscillator division with per-channel divisors loaded over a valid/ready port.
//  Outputs are enables and data-rate square waves, never clocks. They feed LED, UART-baud and timer logic
//  in the same clock domain.
// PARAMETERS
//  NUM_CH   4    number of independent channels (1..16)
//  DIV_W    8    divisor/counter width; legal divisor 2..2**DIV_W-1
//  DEF_DIV  2    divisor loaded into every channel at reset (must be >=2)
// PORTS
//  clk        in   1               oscillator clock, single domain
//  rst_n      in   1               asynchronous active-low reset
//  en_i       in   NUM_CH          per-channel run enable (level, synchronous to clk)
//  sync_i     in   1               pulse: restart all enabled counters in phase
//  cfg_valid  in   1               divisor write request
//  cfg_ready  out  1               write accepted when cfg_valid&cfg_ready
//  cfg_ch     in   4               target channel index
//  cfg_div    in   DIV_W           new divisor
//  cfg_err_o  out  1               1-cycle pulse: accepted write hit cfg_ch>=NUM_CH
//  tick_o     out  NUM_CH          1-cycle pulse per divisor period
//  sq_o       out  NUM_CH          divided square wave
// BEHAVIOUR
//  Reset: cnt=0, div_q=DEF_DIV, pend=0, tick_o=0, sq_o=0, cfg_err_o=0. All outputs are registered.
//  Counting, when en_i[c]=1:
//   - cnt advances +1 per clk. At cnt==div_q-1 (terminal) it wraps to 0.
//   - tick_o[c] is high exactly in the cycle after terminal, giving period = div_q cycles.
//  Square wave: sq_o[c] is registered (cnt < div_q>>1).
//   - High floor(div/2) cycles, low ceil(div/2) cycles. Lag is 1 cycle, same as tick.
//  Disable:
//   - While en_i[c]=0, cnt is held 0 and tick_o/sq_o are 0 from the next cycle.
//   - On re-enable, the first tick occurs div_q+1 cycles after en_i rises.
//  sync_i: every channel clears cnt to 0 next cycle. No tick is emitted for the truncated period.
//   - Simultaneous with a terminal count: sync wins and the tick is suppressed.
//  Config handshake:
//   - cfg_ready = ~pend[cfg_ch]. For cfg_ch>=NUM_CH, cfg_ready=1.
//   - cfg_div<2 is clamped to 2.
//   - Channel disabled: div_q <= value immediately and cnt <= 0.
//   - Channel enabled: value goes to div_p with pend=1. At the next terminal count, div_q <= div_p,
//     pend <= 0, and cnt wraps to 0, so switching is glitch-free and no partial period occurs.
//   - Write in the same cycle as a terminal count: not applied at that terminal; applied at the
//     following one.
//   - Channel disabled while pend=1: div_p is applied immediately and pend is cleared.
//   - Invalid channel: the write is dropped and cfg_err_o pulses the next cycle.
//   - cfg_valid held with cfg_ready=0 stalls with no side effect; cfg_ch/cfg_div must stay stable.
//  Reset mid-operation clears pending writes. The async assert takes effect immediately.
//  Deassertion is synchronised externally.
// STRUCTURE
//  osc_tick_pkg:
//   - DIV_MIN=2, the CH_IDX_W=4 constant.
//   - The channel state struct {cnt, div_q, div_p, pend}.
//  Sub-module osc_tick_ch, one per channel via generate:
//   - Owns the counter, pending register, tick and sq.
//  Top level:
//   - Decodes cfg_ch, drives cfg_ready/cfg_err_o.
//   - Fans out sync_i and the write strobes.
// TESTING
//  1 Reset, en_i=4'b0001, DEF_DIV=2 -> tick_o[0] every 2 cycles, first tick 3 cycles after en; sq_o[0] 1010..
//  2 Ch1 disabled, write div=5, enable -> tick_o[1] period 5, sq_o[1] high 2 / low 3 cycles.
//  3 Ch0 running div=4:
//     - Write div=7 mid-period -> cfg_ready drops until the next terminal.
//     - Exactly one 4-period completes, then the 7-periods follow.
//     - A second write during pend stalls.
//  4 Write div=0 and div=1 -> both behave as div=2. Write cfg_ch=9 with NUM_CH=4 -> cfg_err_o pulse,
//    no channel changes.
//  5 Ch0 div=3 and ch1 div=6 running, assert sync_i -> both cnt=0 next cycle, ticks aligned
//    every 6 cycles; sync on a terminal count suppresses that tick.
//  6 Assert rst_n=0 mid-count with pend=1 -> all outputs 0 at once; after release div_q=DEF_DIV
//    and pend=0.

Source files
------------

// File: rtl/osc_tick_pkg.sv
// Shared constants, per-channel state record and divisor clamp for the oscillator tick generator.
package osc_tick_pkg;

   localparam int DIV_MIN   = 2;
   localparam int CH_IDX_W  = 4;
   localparam int OSC_DIV_W = 8;

   typedef struct packed {
      logic [OSC_DIV_W-1:0] cnt;
      logic [OSC_DIV_W-1:0] div_q;
      logic [OSC_DIV_W-1:0] div_p;
      logic                 pend;
   } ch_state_t;

   // Divisors below 2 cannot produce a tick and a square wave, so they are raised to 2.
   function automatic logic [OSC_DIV_W-1:0] clamp_div(input logic [OSC_DIV_W-1:0] d);
      return (d < OSC_DIV_W'(DIV_MIN)) ? OSC_DIV_W'(DIV_MIN) : d;
   endfunction

endpackage

// File: rtl/osc_tick_ch.sv
// One divider channel: period counter, pending divisor, registered tick pulse and square wave.
module osc_tick_ch
   import osc_tick_pkg::*;
#(
   parameter int DEF_DIV = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 en_i,
   input  logic                 sync_i,
   input  logic                 wr_i,
   input  logic [OSC_DIV_W-1:0] wr_div_i,
   output logic                 pend_o,
   output logic                 tick_o,
   output logic                 sq_o
);

   ch_state_t            st_q, st_d;
   logic                 en_q, en_d;
   logic                 tick_q, tick_d;
   logic                 sq_q, sq_d;
   logic                 run;
   logic                 wrap;
   logic [OSC_DIV_W-1:0] div_c;

   always_comb begin
      div_c  = clamp_div(wr_div_i);
      // The first enabled cycle only arms the channel, so a fresh start spans div_q+1 cycles.
      run    = en_i & en_q;
      wrap   = run & ~sync_i & (st_q.cnt == st_q.div_q - 1'b1);
      st_d   = st_q;
      en_d   = en_i;
      tick_d = wrap;
      sq_d   = run & (st_q.cnt < (st_q.div_q >> 1));
      if (!en_i) begin
         st_d.cnt = '0;
         if (st_q.pend) begin
            st_d.div_q = st_q.div_p;
            st_d.pend  = 1'b0;
         end
         if (wr_i) begin
            st_d.div_q = div_c;
         end
      end else begin
         if (sync_i || wrap) begin
            st_d.cnt = '0;
         end else if (run) begin
            st_d.cnt = st_q.cnt + 1'b1;
         end
         // A queued divisor only takes over at a period boundary, so no period is cut short.
         if (wrap && st_q.pend) begin
            st_d.div_q = st_q.div_p;
            st_d.pend  = 1'b0;
         end
         if (wr_i) begin
            st_d.div_p = div_c;
            st_d.pend  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_q.cnt   <= '0;
         st_q.div_q <= OSC_DIV_W'(DEF_DIV);
         st_q.div_p <= OSC_DIV_W'(DEF_DIV);
         st_q.pend  <= 1'b0;
         en_q       <= 1'b0;
         tick_q     <= 1'b0;
         sq_q       <= 1'b0;
      end else begin
         st_q       <= st_d;
         en_q       <= en_d;
         tick_q     <= tick_d;
         sq_q       <= sq_d;
      end
   end

   assign pend_o = st_q.pend;
   assign tick_o = tick_q;
   assign sq_o   = sq_q;

endmodule

// File: rtl/osc_tick_gen.sv
// Multi-channel programmable tick / square-wave generator; decodes the divisor write port.
module osc_tick_gen
   import osc_tick_pkg::*;
#(
   parameter int NUM_CH  = 4,
   parameter int DIV_W   = OSC_DIV_W,
   parameter int DEF_DIV = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NUM_CH-1:0]   en_i,
   input  logic                sync_i,
   input  logic                cfg_valid,
   output logic                cfg_ready,
   input  logic [CH_IDX_W-1:0] cfg_ch,
   input  logic [DIV_W-1:0]    cfg_div,
   output logic                cfg_err_o,
   output logic [NUM_CH-1:0]   tick_o,
   output logic [NUM_CH-1:0]   sq_o
);

   localparam int SLOTS = 1 << CH_IDX_W;

   logic [NUM_CH-1:0] pend;
   logic [SLOTS-1:0]  pend_all;
   logic [NUM_CH-1:0] wr;
   logic              ch_ok;
   logic              acc_ok;
   logic              err_d, err_q;

   // Unpopulated channel slots read as never pending, so writes to them are accepted and dropped.
   always_comb begin
      pend_all               = '0;
      pend_all[NUM_CH-1:0]   = pend;
      ch_ok                  = ({1'b0, cfg_ch} < (CH_IDX_W + 1)'(NUM_CH));
      cfg_ready              = ~ch_ok | ~pend_all[cfg_ch];
      acc_ok                 = cfg_valid & cfg_ready & ch_ok;
      err_d                  = cfg_valid & ~ch_ok;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign cfg_err_o = err_q;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
         assign wr[gi] = acc_ok & (cfg_ch == CH_IDX_W'(gi));

         osc_tick_ch #(
            .DEF_DIV (DEF_DIV)
         ) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .en_i     (en_i[gi]),
            .sync_i   (sync_i),
            .wr_i     (wr[gi]),
            .wr_div_i (OSC_DIV_W'(cfg_div)),
            .pend_o   (pend[gi]),
            .tick_o   (tick_o[gi]),
            .sq_o     (sq_o[gi])
         );
      end
   endgenerate

endmodule

// File: tb/tb_osc_tick_gen.sv
// Bench for osc_tick_gen: fixed vector table, directed corner sequences and a random run against a period model.
module tb_osc_tick_gen;

   localparam int NCH = 4;
   localparam int DW  = 8;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [NCH-1:0] en_i = '0;
   logic           sync_i = 1'b0;
   logic           cfg_valid = 1'b0;
   logic           cfg_ready;
   logic [3:0]     cfg_ch = '0;
   logic [DW-1:0]  cfg_div = '0;
   logic           cfg_err_o;
   logic [NCH-1:0] tick_o;
   logic [NCH-1:0] sq_o;

   always #5 clk = ~clk;

   osc_tick_gen #(
      .NUM_CH  (NCH),
      .DIV_W   (DW),
      .DEF_DIV (2)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en_i      (en_i),
      .sync_i    (sync_i),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_ch    (cfg_ch),
      .cfg_div   (cfg_div),
      .cfg_err_o (cfg_err_o),
      .tick_o    (tick_o),
      .sq_o      (sq_o)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;
   int tq0[$];
   int tq1[$];

   // Reference: each channel is a divisor, an optional queued divisor and a position within its period.
   int             m_div[NCH];
   int             m_pdiv[NCH];
   int             m_pos[NCH];
   bit             m_pend[NCH];
   bit             m_live[NCH];
   logic [NCH-1:0] e_tick;
   logic [NCH-1:0] e_sq;
   logic           e_err;

   typedef struct {
      bit         rst;
      logic [3:0] en;
      logic       sync;
      logic       valid;
      logic [3:0] ch;
      logic [7:0] div;
      logic [3:0] tk;
      logic [3:0] sq;
      logic       err;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(bit rst, logic [3:0] en, logic sync, logic valid, logic [3:0] ch,
                               logic [7:0] div, logic [3:0] tk, logic [3:0] sq, logic err);
      vec_t v;
      v.rst = rst; v.en = en; v.sync = sync; v.valid = valid; v.ch = ch;
      v.div = div; v.tk = tk; v.sq = sq; v.err = err;
      return v;
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
      end
   endtask

   function automatic bit model_ready();
      if (int'(cfg_ch) >= NCH) return 1'b1;
      return !m_pend[int'(cfg_ch)];
   endfunction

   task automatic model_reset();
      for (int c = 0; c < NCH; c++) begin
         m_div[c] = 2; m_pdiv[c] = 2; m_pos[c] = 0; m_pend[c] = 0; m_live[c] = 0;
      end
      e_tick = '0; e_sq = '0; e_err = 1'b0;
   endtask

   task automatic model_edge();
      bit acc, w;
      int val;
      acc   = cfg_valid && model_ready();
      val   = (int'(cfg_div) < 2) ? 2 : int'(cfg_div);
      e_err = cfg_valid && (int'(cfg_ch) >= NCH);
      for (int c = 0; c < NCH; c++) begin
         w = acc && (int'(cfg_ch) == c);
         e_tick[c] = 1'b0;
         e_sq[c]   = 1'b0;
         if (!en_i[c]) begin
            m_live[c] = 0;
            m_pos[c]  = 0;
            if (m_pend[c]) begin m_div[c] = m_pdiv[c]; m_pend[c] = 0; end
            if (w) m_div[c] = val;
         end else begin
            if (m_live[c]) begin
               e_sq[c] = (m_pos[c] < m_div[c] / 2);
               if (sync_i) begin
                  m_pos[c] = 0;
               end else if (m_pos[c] == m_div[c] - 1) begin
                  e_tick[c] = 1'b1;
                  m_pos[c]  = 0;
                  if (m_pend[c]) begin m_div[c] = m_pdiv[c]; m_pend[c] = 0; end
               end else begin
                  m_pos[c]++;
               end
            end
            m_live[c] = 1;
            if (w) begin m_pdiv[c] = val; m_pend[c] = 1; end
         end
      end
   endtask

   task automatic step();
      check("cfg_ready", cfg_ready, model_ready());
      model_edge();
      @(posedge clk);
      #1;
      cyc++;
      if (tick_o[0]) tq0.push_back(cyc);
      if (tick_o[1]) tq1.push_back(cyc);
      check("tick_o", tick_o, e_tick);
      check("sq_o", sq_o, e_sq);
      check("cfg_err_o", cfg_err_o, e_err);
   endtask

   task automatic do_reset();
      en_i = '0; sync_i = 1'b0; cfg_valid = 1'b0; cfg_ch = '0; cfg_div = '0;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check("rst_tick", tick_o, 0);
      check("rst_sq", sq_o, 0);
      check("rst_err", cfg_err_o, 0);
      check("rst_ready", cfg_ready, 1);
      rst_n = 1'b1;
      model_reset();
   endtask

   initial begin
      int  tprev, s, nt;
      bit  found;

      // Test 1: default divisor 2 on ch0.
      tbl.push_back(mk(1, 4'h1, 0, 0, 0, 0, 4'h0, 4'h0, 0));
      tbl.push_back(mk(0, 4'h1, 0, 0, 0, 0, 4'h0, 4'h1, 0));
      tbl.push_back(mk(0, 4'h1, 0, 0, 0, 0, 4'h1, 4'h0, 0));
      tbl.push_back(mk(0, 4'h1, 0, 0, 0, 0, 4'h0, 4'h1, 0));
      tbl.push_back(mk(0, 4'h1, 0, 0, 0, 0, 4'h1, 4'h0, 0));
      // Test 2: ch1 loaded with 5 while idle, then enabled.
      tbl.push_back(mk(1, 4'h0, 0, 1, 1, 5, 4'h0, 4'h0, 0));
      tbl.push_back(mk(0, 4'h2, 0, 0, 0, 0, 4'h0, 4'h0, 0));
      tbl.push_back(mk(0, 4'h2, 0, 0, 0, 0, 4'h0, 4'h2, 0));
      tbl.push_back(mk(0, 4'h2, 0, 0, 0, 0, 4'h0, 4'h2, 0));
      tbl.push_back(mk(0, 4'h2, 0, 0, 0, 0, 4'h0, 4'h0, 0));
      tbl.push_back(mk(0, 4'h2, 0, 0, 0, 0, 4'h0, 4'h0, 0));
      tbl.push_back(mk(0, 4'h2, 0, 0, 0, 0, 4'h2, 4'h0, 0));
      tbl.push_back(mk(0, 4'h2, 0, 0, 0, 0, 4'h0, 4'h2, 0));
      tbl.push_back(mk(0, 4'h2, 0, 0, 0, 0, 4'h0, 4'h2, 0));
      tbl.push_back(mk(0, 4'h2, 0, 0, 0, 0, 4'h0, 4'h0, 0));
      tbl.push_back(mk(0, 4'h2, 0, 0, 0, 0, 4'h0, 4'h0, 0));
      tbl.push_back(mk(0, 4'h2, 0, 0, 0, 0, 4'h2, 4'h0, 0));
      // Test 4: clamped divisors and an out-of-range channel write.
      tbl.push_back(mk(1, 4'h0, 0, 1, 0, 0, 4'h0, 4'h0, 0));
      tbl.push_back(mk(0, 4'h0, 0, 1, 1, 1, 4'h0, 4'h0, 0));
      tbl.push_back(mk(0, 4'h0, 0, 1, 9, 5, 4'h0, 4'h0, 1));
      tbl.push_back(mk(0, 4'hF, 0, 0, 0, 0, 4'h0, 4'h0, 0));
      tbl.push_back(mk(0, 4'hF, 0, 0, 0, 0, 4'h0, 4'hF, 0));
      tbl.push_back(mk(0, 4'hF, 0, 0, 0, 0, 4'hF, 4'h0, 0));
      tbl.push_back(mk(0, 4'hF, 0, 0, 0, 0, 4'h0, 4'hF, 0));
      tbl.push_back(mk(0, 4'hF, 0, 0, 0, 0, 4'hF, 4'h0, 0));

      for (int i = 0; i < tbl.size(); i++) begin
         if (tbl[i].rst) do_reset();
         en_i = tbl[i].en; sync_i = tbl[i].sync; cfg_valid = tbl[i].valid;
         cfg_ch = tbl[i].ch; cfg_div = tbl[i].div;
         step();
         $display("vec %0d en=%h valid=%b ch=%0d div=%0d -> tick=%h sq=%h err=%b",
                  i, tbl[i].en, tbl[i].valid, tbl[i].ch, tbl[i].div, tick_o, sq_o, cfg_err_o);
         check("vec_tick", tick_o, tbl[i].tk);
         check("vec_sq", sq_o, tbl[i].sq);
         check("vec_err", cfg_err_o, tbl[i].err);
      end

      // Test 3: divisor change 4 -> 7 while running, second write stalls.
      do_reset();
      cfg_valid = 1; cfg_ch = 0; cfg_div = 4; step();
      cfg_valid = 0; en_i = 4'h1;
      found = 0;
      for (int i = 0; i < 12 && !found; i++) begin
         step();
         if (tick_o[0]) found = 1;
      end
      check("t3_first_tick", found, 1);
      tprev = cyc;
      tq0.delete();
      step();
      cfg_valid = 1; cfg_div = 7;
      check("t3_ready_idle", cfg_ready, 1);
      step();
      cfg_div = 9;
      for (int i = 0; i < 2; i++) begin
         check("t3_stall_ready", cfg_ready, 0);
         step();
      end
      cfg_valid = 0;
      repeat (20) step();
      $display("t3 ticks after cycle %0d: %p", tprev, tq0);
      check("t3_nticks", tq0.size() >= 3, 1);
      if (tq0.size() >= 3) begin
         check("t3_last_4_period", tq0[0] - tprev, 4);
         check("t3_first_7_period", tq0[1] - tq0[0], 7);
         check("t3_second_7_period", tq0[2] - tq0[1], 7);
      end

      // Test 5: sync alignment of div 3 and div 6, then sync on a terminal count.
      do_reset();
      cfg_valid = 1; cfg_ch = 0; cfg_div = 3; step();
      cfg_ch = 1; cfg_div = 6; step();
      cfg_valid = 0; en_i = 4'h3;
      repeat (4) step();
      sync_i = 1; step(); sync_i = 0;
      s = cyc;
      $display("t5 sync at cycle %0d", s);
      for (int i = 1; i <= 11; i++) begin
         step();
         check("t5_tick0", tick_o[0], (i % 3 == 0));
         check("t5_tick1", tick_o[1], (i == 6));
      end
      sync_i = 1; step(); sync_i = 0;
      check("t5_sync_on_term", tick_o, 0);
      repeat (8) step();

      // Test 6: asynchronous reset with a write pending.
      do_reset();
      cfg_valid = 1; cfg_ch = 0; cfg_div = 4; step();
      cfg_valid = 0; en_i = 4'h1;
      repeat (5) step();
      cfg_valid = 1; cfg_div = 7; step();
      cfg_valid = 0;
      check("t6_pend_ready", cfg_ready, 0);
      #2 rst_n = 1'b0;
      #1;
      check("t6_async_tick", tick_o, 0);
      check("t6_async_sq", sq_o, 0);
      check("t6_async_err", cfg_err_o, 0);
      check("t6_async_ready", cfg_ready, 1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
      tq0.delete();
      repeat (8) step();
      nt = tq0.size();
      check("t6_def_div_ticks", nt, 3);
      check("t6_ready_after", cfg_ready, 1);

      // Random run against the model; a stalled request keeps its channel and divisor.
      do_reset();
      en_i = 4'($urandom);
      for (int i = 0; i < 3000; i++) begin
         if (!(cfg_valid && !model_ready())) begin
            cfg_valid = ($urandom % 3 == 0);
            cfg_ch    = ($urandom % 5 == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
            cfg_div   = ($urandom % 4 == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 9));
         end
         if ($urandom % 40 == 0) en_i[$urandom_range(0, 3)] ^= 1'b1;
         sync_i = ($urandom % 50 == 0);
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
